// File: rtl/aes_block_packer_pkg.sv
// aes_block_packer_pkg: shared AES block types, FSM states and padding helpers
package aes_block_packer_pkg;
  localparam int AES_BLOCK_BYTES = 16;
  typedef logic [127:0] block_t;
  typedef enum logic {FILL, PAD} state_t;
  function automatic block_t pad_fill(block_t b, logic [4:0] n, logic [7:0] v);
    block_t r;
    r = b;
    for (int k = 0; k < AES_BLOCK_BYTES; k++)
      if (k >= int'(n)) r[8*(15-k) +: 8] = v;
    return r;
  endfunction
  function automatic block_t pkcs7_pad(block_t b, logic [4:0] n);
    return pad_fill(b, n, 8'(AES_BLOCK_BYTES - int'(n)));
  endfunction
endpackage

// File: rtl/aes_axis_out_reg.sv
// aes_axis_out_reg: one-entry AXI-Stream output register with valid/ready
module aes_axis_out_reg #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         last,
  output logic         can_load,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  output logic         m_tlast,
  input  logic         m_tready
);
  assign can_load = !m_tvalid || m_tready;
  always_ff @(posedge clk) begin
    if (reset) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (load) begin
      m_tdata  <= data;
      m_tvalid <= 1'b1;
      m_tlast  <= last;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end
  end
endmodule

// File: rtl/aes_block_packer.sv
// aes_block_packer: packs an AXI-Stream byte stream into padded 128-bit AES blocks
module aes_block_packer
  import aes_block_packer_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter bit PAD_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_WIDTH-1:0]   s_tdata,
  input  logic [IN_WIDTH/8-1:0] s_tkeep,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [127:0]          m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic                  keep_err
);
  localparam int KB = IN_WIDTH / 8;
  state_t     state;
  block_t     acc, merged, ld_data;
  logic [3:0] cnt;
  logic [4:0] lead, nb, cnt_after;
  logic       run, legal, done, go, load, ld_last, can_load, exact;
  always_comb begin
    lead = '0;
    run  = 1'b1;
    for (int i = KB - 1; i >= 0; i--) begin
      run  = run & s_tkeep[i];
      lead = lead + 5'(run);
    end
    legal     = s_tlast ? (lead != 5'd0 && 5'($countones(s_tkeep)) == lead) : &s_tkeep;
    nb        = legal ? lead : 5'(KB);
    cnt_after = 5'(cnt) + nb;
    exact     = cnt_after == 5'(AES_BLOCK_BYTES);
    merged    = acc;
    for (int i = 0; i < KB; i++)
      if (int'(cnt) + i < AES_BLOCK_BYTES)
        merged[8*(15-int'(cnt)-i) +: 8] = s_tdata[IN_WIDTH-8-8*i +: 8];
    done     = s_tlast || exact;
    s_tready = !reset && state == FILL && !(done && !can_load);
    go       = s_tvalid && s_tready;
    load     = state == PAD ? can_load : go && done;
    ld_last  = state == PAD || (s_tlast && !(PAD_EN && exact));
    ld_data  = state == PAD ? pkcs7_pad(block_t'(0), 5'd0) :
               (!s_tlast || exact) ? merged :
               PAD_EN ? pkcs7_pad(merged, cnt_after) : pad_fill(merged, cnt_after, 8'h00);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FILL;
      acc      <= '0;
      cnt      <= '0;
      keep_err <= 1'b0;
    end else begin
      keep_err <= go && !legal;
      if (state == PAD) begin
        state <= can_load ? FILL : PAD;
      end else if (go) begin
        acc <= merged;
        cnt <= done ? 4'd0 : cnt_after[3:0];
        if (s_tlast && PAD_EN && exact) state <= PAD;
      end
    end
  end
  aes_axis_out_reg #(.W(128)) u_out (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data     (ld_data),
    .last     (ld_last),
    .can_load (can_load),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready)
  );
endmodule

// File: tb/tb_aes_block_packer.sv
// tb_aes_block_packer: byte-queue model checks for a zero-pad (0) and a PKCS#7 (1) packer
module tb_aes_block_packer;
  logic         clk = 1'b0, reset = 1'b1;
  logic [31:0]  s_tdata [2];
  logic [3:0]   s_tkeep [2];
  logic         s_tvalid [2], s_tlast [2], s_tready [2];
  logic [127:0] m_tdata [2];
  logic         m_tvalid [2], m_tlast [2], m_tready [2], keep_err [2];
  int checks = 0, failures = 0;
  logic [7:0]   mb [2][16];
  int           mn [2];
  logic         kpend [2], hv [2];
  logic [128:0] hd [2];
  logic [128:0] eq0 [$], eq1 [$];
  logic [31:0]  nist [8] = '{32'hAE2D8A57, 32'h1E03AC9C, 32'h9EB76FAC, 32'h45AF8E51,
                             32'h30C81C46, 32'hA35CE411, 32'hE5FBC119, 32'h1A0A52EF};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    aes_block_packer #(.IN_WIDTH(32), .PAD_EN(g == 1)) u_dut (
      .clk(clk), .reset(reset), .s_tdata(s_tdata[g]), .s_tkeep(s_tkeep[g]),
      .s_tvalid(s_tvalid[g]), .s_tlast(s_tlast[g]), .s_tready(s_tready[g]),
      .m_tdata(m_tdata[g]), .m_tvalid(m_tvalid[g]), .m_tlast(m_tlast[g]),
      .m_tready(m_tready[g]), .keep_err(keep_err[g]));
  end
  task automatic chk(string n, logic [129:0] a, logic [129:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask
  function automatic void emit(int d, logic [127:0] b, logic l);
    if (d == 0) eq0.push_back({l, b}); else eq1.push_back({l, b});
  endfunction
  // Message bytes gather in a list; a block is cut at 16 bytes or at the last beat.
  function automatic void model_beat(int d, logic [31:0] data, logic [3:0] keep, logic last);
    logic legal;
    int nb;
    logic [127:0] blk;
    legal = last ? (keep inside {4'h8, 4'hC, 4'hE, 4'hF}) : keep == 4'hF;
    nb = !legal ? 4 : keep == 4'h8 ? 1 : keep == 4'hC ? 2 : keep == 4'hE ? 3 : 4;
    for (int i = 0; i < nb; i++) begin
      mb[d][mn[d]] = data[31-8*i -: 8];
      mn[d]++;
    end
    kpend[d] = !legal;
    if (!last && mn[d] < 16) return;
    for (int k = 0; k < 16; k++)
      blk[127-8*k -: 8] = k < mn[d] ? mb[d][k] : (d == 1 ? 8'(16 - mn[d]) : 8'h00);
    if (last && mn[d] == 16 && d == 1) begin
      emit(d, blk, 1'b0);
      emit(d, {16{8'h10}}, 1'b1);
    end else emit(d, blk, last);
    mn[d] = 0;
  endfunction
  always @(negedge clk) begin
    logic [128:0] e;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mn[d] = 0; kpend[d] = 1'b0; hv[d] = 1'b0;
        if (d == 0) eq0.delete(); else eq1.delete();
      end else begin
        chk($sformatf("keep_err%0d", d), 130'(keep_err[d]), 130'(kpend[d]));
        kpend[d] = 1'b0;
        if (hv[d]) chk($sformatf("hold%0d", d), {m_tvalid[d], m_tlast[d], m_tdata[d]}, {1'b1, hd[d]});
        if (m_tvalid[d] && m_tready[d]) begin
          if ((d == 0 ? eq0.size() : eq1.size()) == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_block%0d got=%h want=none", d, m_tdata[d]);
          end else begin
            e = d == 0 ? eq0.pop_front() : eq1.pop_front();
            chk($sformatf("block%0d", d), 130'({m_tlast[d], m_tdata[d]}), 130'(e));
          end
        end
        hv[d] = m_tvalid[d] && !m_tready[d];
        hd[d] = {m_tlast[d], m_tdata[d]};
        if (s_tvalid[d] && s_tready[d]) model_beat(d, s_tdata[d], s_tkeep[d], s_tlast[d]);
      end
    end
  end
  task automatic send(int d, logic [31:0] dat, logic [3:0] k, logic l);
    int w = 0;
    logic ok;
    s_tdata[d] = dat; s_tkeep[d] = k; s_tlast[d] = l; s_tvalid[d] = 1'b1;
    do begin
      @(negedge clk);
      ok = s_tready[d];
      @(posedge clk); #1;
      w++;
    end while (!ok && w < 100);
    s_tvalid[d] = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout%0d got=stalled want=accepted", d);
    end
  endtask
  task automatic step;
    @(posedge clk); #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end
  initial begin
    for (int d = 0; d < 2; d++) begin
      s_tdata[d] = '0; s_tkeep[d] = '0; s_tvalid[d] = 1'b0; s_tlast[d] = 1'b0; m_tready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 130'(m_tvalid[d]), 130'(0));
      chk("rst_data", 130'(m_tdata[d]), 130'(0));
      chk("rst_last", 130'(m_tlast[d]), 130'(0));
      chk("rst_kerr", 130'(keep_err[d]), 130'(0));
      chk("rst_ready", 130'(s_tready[d]), 130'(0));
    end
    step(); reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("ready_after_rst", 130'(s_tready[d]), 130'(1));
    step();
    // zero pad, exact 16 bytes: one block with tlast
    send(0, 32'h6BC1BEE2, 4'hF, 0); send(0, 32'h2E409F96, 4'hF, 0);
    send(0, 32'hE93D7E11, 4'hF, 0); send(0, 32'h7393172A, 4'hF, 1);
    @(negedge clk);
    chk("t1_valid", 130'(m_tvalid[0]), 130'(1));
    chk("t1_block", 130'({m_tlast[0], m_tdata[0]}), {2'b01, 128'h6BC1BEE22E409F96E93D7E117393172A});
    step();
    // PKCS#7, exact 16 bytes: data block then a full pad block
    send(1, 32'h6BC1BEE2, 4'hF, 0); send(1, 32'h2E409F96, 4'hF, 0);
    send(1, 32'hE93D7E11, 4'hF, 0); send(1, 32'h7393172A, 4'hF, 1);
    @(negedge clk);
    chk("t2_data", 130'({m_tvalid[1], m_tlast[1], m_tdata[1]}), {2'b10, 128'h6BC1BEE22E409F96E93D7E117393172A});
    chk("t2_ready_pad", 130'(s_tready[1]), 130'(0));
    step();
    @(negedge clk);
    chk("t2_pad", 130'({m_tvalid[1], m_tlast[1], m_tdata[1]}), {2'b11, {16{8'h10}}});
    chk("t2_ready_fill", 130'(s_tready[1]), 130'(1));
    step();
    send(1, 32'h6BC1BEE2, 4'hF, 0); send(1, 32'h2E000000, 4'h8, 1);
    @(negedge clk);
    chk("t3_block", 130'({m_tlast[1], m_tdata[1]}), {2'b01, 128'h6BC1BEE22E0B0B0B0B0B0B0B0B0B0B0B});
    step();
    // backpressure: block 1 held while the accumulator fills behind it
    m_tready[0] = 1'b0;
    fork
      for (int i = 0; i < 8; i++) send(0, nist[i], 4'hF, i == 7);
      begin
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("t4_ready_low", 130'(s_tready[0]), 130'(0));
        chk("t4_held", 130'({m_tvalid[0], m_tlast[0], m_tdata[0]}), {2'b10, 128'hAE2D8A571E03AC9C9EB76FAC45AF8E51});
        step();
        m_tready[0] = 1'b1;
      end
    join
    @(negedge clk);
    chk("t4_block2", 130'({m_tlast[0], m_tdata[0]}), {2'b01, 128'h30C81C46A35CE411E5FBC1191A0A52EF});
    step();
    send(1, 32'h00112233, 4'h6, 0);
    @(negedge clk);
    chk("t5_kerr_hi", 130'(keep_err[1]), 130'(1));
    step();
    @(negedge clk);
    chk("t5_kerr_lo", 130'(keep_err[1]), 130'(0));
    step();
    send(1, 32'h44556677, 4'hF, 0); send(1, 32'h8899AABB, 4'hF, 0); send(1, 32'hCCDDEEFF, 4'hF, 1);
    @(negedge clk);
    chk("t5_block", 130'({m_tlast[1], m_tdata[1]}), {2'b00, 128'h00112233445566778899AABBCCDDEEFF});
    repeat (3) step();
    // reset with a held block and a partial accumulator
    m_tready[0] = 1'b0;
    for (int i = 0; i < 6; i++) send(0, 32'hDEAD0000 + 32'(i), 4'hF, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_valid_drop", 130'(m_tvalid[0]), 130'(0));
    chk("t6_ready_rst", 130'(s_tready[0]), 130'(0));
    step(); reset = 1'b0; m_tready[0] = 1'b1;
    step();
    send(0, 32'h00010203, 4'hF, 0); send(0, 32'h04050607, 4'hF, 0);
    send(0, 32'h08090A0B, 4'hF, 0); send(0, 32'h0C0D0E0F, 4'hF, 1);
    @(negedge clk);
    chk("t6_fresh", 130'({m_tvalid[0], m_tlast[0], m_tdata[0]}), {2'b11, 128'h000102030405060708090A0B0C0D0E0F});
    repeat (5) step();
    @(negedge clk);
    chk("drain0", 130'(eq0.size()), 130'(0));
    chk("drain1", 130'(eq1.size()), 130'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
